// File: rtl/tx_resp_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tx_resp_arbiter_pkg
// Shared types for the TX response arbiter: scheduler FSM states and the
// response-source identifier used for round-robin bookkeeping.
// -----------------------------------------------------------------------------
package tx_resp_arbiter_pkg;

  localparam int TX_DATA_W = 8;
  localparam int TX_RES_W  = 2 * TX_DATA_W;

  typedef enum logic {
    ARB_IDLE,
    ARB_ALU_HI
  } tx_arb_state_e;

  typedef enum bit {
    SRC_RD,
    SRC_ALU
  } tx_src_e;

endpackage

// File: rtl/tx_resp_arbiter_resp_hold_buf.sv
// -----------------------------------------------------------------------------
// resp_hold_buf
// One-entry holding buffer for a response source.
//   clk, rst_n  : clock / asynchronous active-low reset
//   capture_i   : one-cycle strobe, data_i valid
//   data_i      : word to hold
//   clear_i     : entry is being consumed this cycle
//   pend_o      : entry holds an unsent word
//   buf_o       : held word
//   drop_o      : registered pulse, a capture was refused because the entry
//                 was occupied and not being consumed
// -----------------------------------------------------------------------------
module resp_hold_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         capture_i,
  input  logic [W-1:0] data_i,
  input  logic         clear_i,
  output logic         pend_o,
  output logic [W-1:0] buf_o,
  output logic         drop_o
);

  logic         pend_q, pend_d;
  logic [W-1:0] buf_q, buf_d;
  logic         drop_q, drop_d;
  logic         accept;

  // A slot freed in this same cycle may be refilled, which is what allows
  // back-to-back single-byte responses at full rate.
  assign accept = capture_i && (!pend_q || clear_i);

  always_comb begin
    pend_d = pend_q;
    buf_d  = buf_q;
    drop_d = capture_i && !accept;
    if (accept) begin
      pend_d = 1'b1;
      buf_d  = data_i;
    end else if (clear_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      buf_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      buf_q  <= buf_d;
      drop_q <= drop_d;
    end
  end

  assign pend_o = pend_q;
  assign buf_o  = buf_q;
  assign drop_o = drop_q;

endmodule

// File: rtl/tx_resp_arbiter.sv
// -----------------------------------------------------------------------------
// tx_resp_arbiter
// Shares the UART TX FIFO write port between register-file read bytes and
// 16-bit ALU results (sent LSB first). Each source has a one-entry buffer;
// a round-robin scheduler drains them, never writing while full is high.
//   CLK, RST            : clock / asynchronous active-low reset
//   rd_vld, rd_data     : register-file read byte strobe and data
//   alu_vld, alu_data   : ALU result strobe and data
//   full                : TX FIFO full
//   TX_P_DATA, TX_D_VLD : registered FIFO write data / strobe
//   rd_drop, alu_drop   : registered pulse, a response was lost (buffer busy)
//   busy                : any buffer pending or mid-result
// -----------------------------------------------------------------------------
module tx_resp_arbiter
  import tx_resp_arbiter_pkg::*;
#(
  parameter int DATA_W = TX_DATA_W,
  parameter int RES_W  = TX_RES_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              alu_vld,
  input  logic [RES_W-1:0]  alu_data,
  input  logic              full,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  output logic              rd_drop,
  output logic              alu_drop,
  output logic              busy
);

  tx_arb_state_e     state_q, state_d;
  tx_src_e           last_grant_q, last_grant_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_vld_q, tx_vld_d;

  logic              rd_pend, alu_pend;
  logic [DATA_W-1:0] rd_buf;
  logic [RES_W-1:0]  alu_buf;
  logic              rd_clear, alu_clear;
  logic              grant_rd, grant_alu;

  resp_hold_buf #(.W(DATA_W)) u_rd_buf (
    .clk       (CLK),
    .rst_n     (RST),
    .capture_i (rd_vld),
    .data_i    (rd_data),
    .clear_i   (rd_clear),
    .pend_o    (rd_pend),
    .buf_o     (rd_buf),
    .drop_o    (rd_drop)
  );

  resp_hold_buf #(.W(RES_W)) u_alu_buf (
    .clk       (CLK),
    .rst_n     (RST),
    .capture_i (alu_vld),
    .data_i    (alu_data),
    .clear_i   (alu_clear),
    .pend_o    (alu_pend),
    .buf_o     (alu_buf),
    .drop_o    (alu_drop)
  );

  // On a tie the source that did not win last time is served.
  assign grant_rd  = rd_pend  && (!alu_pend || (last_grant_q == SRC_ALU));
  assign grant_alu = alu_pend && (!rd_pend  || (last_grant_q == SRC_RD));

  // State register (also holds the registered FIFO write port).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= SRC_ALU;
      tx_data_q    <= '0;
      tx_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      tx_vld_q     <= tx_vld_d;
    end
  end

  // Next-state logic. Once the LO byte is out, stay in ALU_HI until the HI
  // byte goes, so nothing can be interleaved inside an ALU result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (!full && !grant_rd && grant_alu) state_d = ARB_ALU_HI;
      ARB_ALU_HI: if (!full) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    tx_data_d    = tx_data_q;
    tx_vld_d     = 1'b0;
    last_grant_d = last_grant_q;
    rd_clear     = 1'b0;
    alu_clear    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!full) begin
          if (grant_rd) begin
            tx_data_d    = rd_buf;
            tx_vld_d     = 1'b1;
            rd_clear     = 1'b1;
            last_grant_d = SRC_RD;
          end else if (grant_alu) begin
            tx_data_d    = alu_buf[DATA_W-1:0];
            tx_vld_d     = 1'b1;
            last_grant_d = SRC_ALU;
          end
        end
      end
      ARB_ALU_HI: begin
        if (!full) begin
          tx_data_d = alu_buf[RES_W-1:DATA_W];
          tx_vld_d  = 1'b1;
          alu_clear = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign busy      = rd_pend || alu_pend || (state_q != ARB_IDLE);

endmodule
